// File: rtl/sincos_pkg.sv
// Shared constants for the SinCos request scheduler.
//   PHASE_BITS     : phase width; full circle = 2^PHASE_BITS
//   OUTPUT_BITS    : signed sin/cos sample width
//   SINCOS_LATENCY : clocks from sincos_phase to valid sin/cos
//   SCHED_LATENCY  : accept edge to rsp_valid edge
package sincos_pkg;

  localparam int PHASE_BITS     = 16;
  localparam int OUTPUT_BITS    = 16;
  localparam int SINCOS_LATENCY = 1;
  localparam int SCHED_LATENCY  = SINCOS_LATENCY + 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant.
// The search begins at the index after `pointer` and wraps to 0.
// Ports:
//   req       in  N     : request vector
//   pointer   in  ID_W  : last granted index
//   grant     out N     : one-hot-or-zero grant
//   grant_id  out ID_W  : index of the granted bit (0 when none)
//   grant_any out 1     : any bit of grant is set
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] pointer,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    // off runs 1..N so the last-granted requester is searched last.
    for (int off = 1; off <= N; off++) begin
      idx = (int'(pointer) + off) % N;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sincos_scheduler.sv
// Shares one external SinCos unit among REQUESTERS clients.
// Round-robin accept, two-edge pipeline (phase register -> SinCos ->
// result register), responses returned in acceptance order.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_phase : per-requester request and packed phases
//   req_ready           : one-hot-or-zero grant (combinational)
//   hold                : blocks new accepts, in-flight work drains
//   sincos_phase        : registered phase to the SinCos unit
//   sincos_sin/cos      : SinCos results, one clk after sincos_phase
//   rsp_valid           : one-hot single-cycle result strobe
//   rsp_sin/rsp_cos     : registered result samples
//   busy                : a pipeline stage holds a valid entry
module sincos_scheduler
  import sincos_pkg::*;
#(
  parameter int REQUESTERS  = 4,
  parameter int PHASE_BITS  = sincos_pkg::PHASE_BITS,
  parameter int OUTPUT_BITS = sincos_pkg::OUTPUT_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [REQUESTERS-1:0]              req_valid,
  input  logic [REQUESTERS*PHASE_BITS-1:0]   req_phase,
  output logic [REQUESTERS-1:0]              req_ready,
  input  logic                               hold,
  output logic [PHASE_BITS-1:0]              sincos_phase,
  input  logic signed [OUTPUT_BITS-1:0]      sincos_sin,
  input  logic signed [OUTPUT_BITS-1:0]      sincos_cos,
  output logic [REQUESTERS-1:0]              rsp_valid,
  output logic signed [OUTPUT_BITS-1:0]      rsp_sin,
  output logic signed [OUTPUT_BITS-1:0]      rsp_cos,
  output logic                               busy
);

  localparam int ID_W = $clog2(REQUESTERS);

  logic [ID_W-1:0]       pointer;
  logic [ID_W-1:0]       grant_id;
  logic [REQUESTERS-1:0] grant;
  logic                  grant_any;
  logic                  accept;

  // s1: phase is in sincos_phase; s2: SinCos output belongs to this entry.
  logic                  s1_valid, s2_valid;
  logic [ID_W-1:0]       s1_id, s2_id;

  rr_arbiter #(
    .N    (REQUESTERS),
    .ID_W (ID_W)
  ) u_arb (
    .req       (req_valid),
    .pointer   (pointer),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (!reset && !hold) begin
      req_ready = grant;
      accept    = grant_any;
    end
  end

  assign busy = s1_valid | s2_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Requester 0 gets first priority out of reset.
      pointer      <= ID_W'(REQUESTERS - 1);
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      s1_id        <= '0;
      s2_id        <= '0;
      sincos_phase <= '0;
      rsp_valid    <= '0;
      rsp_sin      <= '0;
      rsp_cos      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        sincos_phase <= req_phase[grant_id*PHASE_BITS +: PHASE_BITS];
        s1_id        <= grant_id;
        pointer      <= grant_id;
      end
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (s2_valid) begin
        rsp_valid <= REQUESTERS'(1) << s2_id;
        rsp_sin   <= sincos_sin;
        rsp_cos   <= sincos_cos;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sincos_scheduler.sv
module tb_sincos_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic               hold;
  logic [3:0]         req_valid;
  logic [63:0]        req_phase;
  logic [3:0]         req_ready;
  logic [15:0]        sincos_phase;
  logic signed [15:0] sincos_sin;
  logic signed [15:0] sincos_cos;
  logic [3:0]         rsp_valid;
  logic signed [15:0] rsp_sin;
  logic signed [15:0] rsp_cos;
  logic               busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] cph [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h5555};
  logic [15:0] sph [5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
  logic [15:0] ssn [5] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8001, 16'h0000};
  logic [15:0] scs [5] = '{16'h7FFF, 16'h0000, 16'h8001, 16'h0000, 16'h7FFF};

  always #5 clk = ~clk;

  sincos_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_phase    (req_phase),
    .req_ready    (req_ready),
    .hold         (hold),
    .sincos_phase (sincos_phase),
    .sincos_sin   (sincos_sin),
    .sincos_cos   (sincos_cos),
    .rsp_valid    (rsp_valid),
    .rsp_sin      (rsp_sin),
    .rsp_cos      (rsp_cos),
    .busy         (busy)
  );

  // Stand-in SinCos unit: exact at the quadrant points, distinct
  // arbitrary values elsewhere so data routing is visible.
  function automatic logic [15:0] m_sin(input logic [15:0] p);
    case (p)
      16'h0000: m_sin = 16'h0000;
      16'h4000: m_sin = 16'h7FFF;
      16'h8000: m_sin = 16'h0000;
      16'hC000: m_sin = 16'h8001;
      default:  m_sin = p ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [15:0] m_cos(input logic [15:0] p);
    case (p)
      16'h0000: m_cos = 16'h7FFF;
      16'h4000: m_cos = 16'h0000;
      16'h8000: m_cos = 16'h8001;
      16'hC000: m_cos = 16'h0000;
      default:  m_cos = ~p;
    endcase
  endfunction

  always @(posedge clk) begin
    sincos_sin <= m_sin(sincos_phase);
    sincos_cos <= m_cos(sincos_phase);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = 4'b1111;
    req_phase = '0;

    // Reset state, with requests pending during reset
    tick(); tick(); tick();
    check("rst_ready",  16'(req_ready),  16'h0000);
    check("rst_phase",  sincos_phase,    16'h0000);
    check("rst_rspv",   16'(rsp_valid),  16'h0000);
    check("rst_sin",    rsp_sin,         16'h0000);
    check("rst_cos",    rsp_cos,         16'h0000);
    check("rst_busy",   16'(busy),       16'h0000);

    // First request, requester 0, phase 0
    reset     = 1'b0;
    req_valid = 4'b0001;
    req_phase[0*16 +: 16] = 16'h0000;
    #1;
    check("r0_ready",   16'(req_ready),  16'h0001);
    tick();
    req_valid = 4'b0000;
    check("r0_phase",   sincos_phase,    16'h0000);
    check("r0_busy1",   16'(busy),       16'h0001);
    check("r0_rspv_e1", 16'(rsp_valid),  16'h0000);
    tick();
    check("r0_rspv_e2", 16'(rsp_valid),  16'h0000);
    tick();
    check("r0_rspv",    16'(rsp_valid),  16'h0001);
    check("r0_sin",     rsp_sin,         16'h0000);
    check("r0_cos",     rsp_cos,         16'h7FFF);
    check("r0_busy0",   16'(busy),       16'h0000);

    // Quarter turn on requester 2
    req_valid = 4'b0100;
    req_phase[2*16 +: 16] = 16'h4000;
    #1;
    check("q_ready",    16'(req_ready),  16'h0004);
    tick();
    req_valid = 4'b0000;
    check("q_phase",    sincos_phase,    16'h4000);
    tick();
    tick();
    check("q_rspv",     16'(rsp_valid),  16'h0004);
    check("q_sin",      rsp_sin,         16'h7FFF);
    check("q_cos",      rsp_cos,         16'h0000);
    tick();
    check("q_rspv_off", 16'(rsp_valid),  16'h0000);
    check("q_sin_hold", rsp_sin,         16'h7FFF);
    check("q_cos_hold", rsp_cos,         16'h0000);

    // Reset with a request in flight: pointer is 2, so search 3 then 0
    req_valid = 4'b0001;
    req_phase[0*16 +: 16] = 16'h0123;
    #1;
    check("rif_ready",  16'(req_ready),  16'h0001);
    tick();
    reset = 1'b1;
    #1;
    check("rif_ready_rst", 16'(req_ready), 16'h0000);
    tick();
    check("rif_rspv_a", 16'(rsp_valid),  16'h0000);
    check("rif_busy",   16'(busy),       16'h0000);
    check("rif_phase",  sincos_phase,    16'h0000);
    reset     = 1'b0;
    req_valid = 4'b0000;
    tick();
    check("rif_rspv_b", 16'(rsp_valid),  16'h0000);
    tick();
    check("rif_rspv_c", 16'(rsp_valid),  16'h0000);

    // Full contention for 8 cycles; pointer restarted, so 0 goes first
    for (int i = 0; i < 4; i++) req_phase[i*16 +: 16] = cph[i];
    for (int j = 0; j < 10; j++) begin
      req_valid = (j < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (j < 8) check($sformatf("cont_ready_%0d", j), 16'(req_ready), 16'(1 << (j % 4)));
      tick();
      if (j >= 2) begin
        check($sformatf("cont_rspv_%0d", j), 16'(rsp_valid), 16'(1 << ((j - 2) % 4)));
        check($sformatf("cont_sin_%0d", j),  rsp_sin, m_sin(cph[(j - 2) % 4]));
        check($sformatf("cont_cos_%0d", j),  rsp_cos, m_cos(cph[(j - 2) % 4]));
      end else begin
        check($sformatf("cont_rspv_%0d", j), 16'(rsp_valid), 16'h0000);
      end
    end
    tick();
    check("cont_drained", 16'(rsp_valid), 16'h0000);
    check("cont_busy",    16'(busy),      16'h0000);

    // Hold while requester 1 is in flight
    req_valid = 4'b0010;
    req_phase[1*16 +: 16] = 16'h2000;
    #1;
    check("hold_ready0", 16'(req_ready), 16'h0002);
    tick();
    hold      = 1'b1;
    req_valid = 4'b1000;
    #1;
    check("hold_ready1", 16'(req_ready), 16'h0000);
    check("hold_busy1",  16'(busy),      16'h0001);
    tick();
    check("hold_ready2", 16'(req_ready), 16'h0000);
    check("hold_busy2",  16'(busy),      16'h0001);
    check("hold_rspv2",  16'(rsp_valid), 16'h0000);
    tick();
    check("hold_rspv",   16'(rsp_valid), 16'h0002);
    check("hold_sin",    rsp_sin,        m_sin(16'h2000));
    check("hold_cos",    rsp_cos,        m_cos(16'h2000));
    check("hold_busy3",  16'(busy),      16'h0000);
    check("hold_ready3", 16'(req_ready), 16'h0000);
    tick();
    check("hold_rspv4",  16'(rsp_valid), 16'h0000);
    check("hold_busy4",  16'(busy),      16'h0000);
    // Pointer must still be 1: search order 2,3,0 picks 3
    hold      = 1'b0;
    req_valid = 4'b1001;
    #1;
    check("hold_ptr",    16'(req_ready), 16'h0008);
    req_valid = 4'b0000;

    // Single requester streaming back-to-back
    for (int j = 0; j < 7; j++) begin
      if (j < 5) begin
        req_valid = 4'b1000;
        req_phase[3*16 +: 16] = sph[j];
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (j < 5) check($sformatf("str_ready_%0d", j), 16'(req_ready), 16'h0008);
      tick();
      if (j >= 2) begin
        check($sformatf("str_rspv_%0d", j), 16'(rsp_valid), 16'h0008);
        check($sformatf("str_sin_%0d", j),  rsp_sin, ssn[j - 2]);
        check($sformatf("str_cos_%0d", j),  rsp_cos, scs[j - 2]);
      end else begin
        check($sformatf("str_rspv_%0d", j), 16'(rsp_valid), 16'h0000);
      end
    end
    tick();
    check("str_done_rspv", 16'(rsp_valid), 16'h0000);
    check("str_done_busy", 16'(busy),      16'h0000);
    check("str_sin_hold",  rsp_sin,        16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
